// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Contents: FSM state encoding, requester (owner) encoding and bus widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VGA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU port, VGA refresh port and memory-decoder port of the
// data-memory arbiter.
//   slave  : arbiter view (takes requests, drives grants/responses/strobes)
//   master : environment view (CPU, VGA reader, decoder and bank mux)
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // CPU data port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  // VGA refresh read port
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_err;

  // Decoder / bank side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_invalid;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rvalid, vga_rdata, vga_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_invalid
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rvalid, vga_rdata, vga_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_invalid
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick2.sv
// Two-way combinational pick between CPU and VGA.
//   cpu_req, vga_req : live requests
//   last_owner       : owner of the previous pick
//   valid            : at least one request present
//   owner            : chosen requester
// RR_ENABLE=1 alternates on a tie; RR_ENABLE=0 gives the CPU fixed priority.
module arb_pick2
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic   cpu_req,
  input  logic   vga_req,
  input  owner_e last_owner,
  output logic   valid,
  output owner_e owner
);

  always_comb begin
    valid = cpu_req | vga_req;
    owner = OWN_CPU;
    if (cpu_req && vga_req) begin
      if (RR_ENABLE && (last_owner == OWN_CPU)) owner = OWN_VGA;
    end else if (vga_req) begin
      owner = OWN_VGA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequential arbiter sharing the data-memory path between the CPU data port
// and the VGA refresh reader. One access at a time: IDLE samples requests,
// ACCESS drives the decoder strobes for one cycle, WAIT captures read data,
// and the owner's rvalid pulses in the following IDLE cycle.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : CPU / VGA / decoder signals (slave view)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
  logic [DATA_W-1:0] issue_wdata_q, issue_wdata_d;
  logic              issue_we_q, issue_we_d;
  logic              err_q, err_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vga_rvalid_q, vga_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic              cpu_err_q, cpu_err_d;
  logic              vga_err_q, vga_err_d;

  logic              pick_valid;
  owner_e            pick_owner;
  logic [DATA_W-1:0] resp_data;

  arb_pick2 #(.RR_ENABLE(RR_ENABLE)) u_pick (
    .cpu_req    (bus.cpu_req),
    .vga_req    (bus.vga_req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    issue_addr_d  = issue_addr_q;
    issue_wdata_d = issue_wdata_q;
    issue_we_d    = issue_we_q;
    err_d         = err_q;
    cpu_rdata_d   = cpu_rdata_q;
    vga_rdata_d   = vga_rdata_q;
    cpu_rvalid_d  = 1'b0;
    vga_rvalid_d  = 1'b0;
    cpu_err_d     = 1'b0;
    vga_err_d     = 1'b0;
    // Writes and rejected addresses return zero rather than bank data.
    resp_data     = (issue_we_q || err_q) ? '0 : bus.mem_rdata;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ACCESS;
          owner_d      = pick_owner;
          last_owner_d = pick_owner;
          if (pick_owner == OWN_CPU) begin
            issue_addr_d  = bus.cpu_addr;
            issue_we_d    = bus.cpu_we;
            issue_wdata_d = bus.cpu_wdata;
          end else begin
            // VGA only reads; mem_wdata keeps its last CPU value.
            issue_addr_d = bus.vga_addr;
            issue_we_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        err_d   = bus.mem_invalid;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = IDLE;
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d  = resp_data;
          cpu_rvalid_d = 1'b1;
          cpu_err_d    = err_q;
        end else begin
          vga_rdata_d  = resp_data;
          vga_rvalid_d = 1'b1;
          vga_err_d    = err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_CPU;
      last_owner_q  <= OWN_VGA;
      issue_addr_q  <= '0;
      issue_wdata_q <= '0;
      issue_we_q    <= 1'b0;
      err_q         <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      vga_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      vga_rdata_q   <= '0;
      cpu_err_q     <= 1'b0;
      vga_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      issue_addr_q  <= issue_addr_d;
      issue_wdata_q <= issue_wdata_d;
      issue_we_q    <= issue_we_d;
      err_q         <= err_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      vga_rvalid_q  <= vga_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      vga_rdata_q   <= vga_rdata_d;
      cpu_err_q     <= cpu_err_d;
      vga_err_q     <= vga_err_d;
    end
  end

  // Grants and strobes decode straight from the state register so that an
  // asynchronous reset drops them in the same cycle.
  assign bus.cpu_gnt    = (state_q == ACCESS) && (owner_q == OWN_CPU);
  assign bus.vga_gnt    = (state_q == ACCESS) && (owner_q == OWN_VGA);
  assign bus.mem_read   = (state_q == ACCESS) && !issue_we_q;
  assign bus.mem_write  = (state_q == ACCESS) && issue_we_q;
  assign bus.mem_addr   = issue_addr_q;
  assign bus.mem_wdata  = issue_wdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.vga_err    = vga_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin instance (r) and a
// fixed-priority instance (f) share clock and reset.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if r ();
  mem_bus_arbiter_if f ();

  mem_bus_arbiter #(.RR_ENABLE(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(r));
  mem_bus_arbiter #(.RR_ENABLE(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cpu_cnt;
    int vga_cnt;

    r.cpu_req = 0; r.cpu_we = 0; r.cpu_addr = '0; r.cpu_wdata = '0;
    r.vga_req = 0; r.vga_addr = '0; r.mem_rdata = '0; r.mem_invalid = 0;
    f.cpu_req = 0; f.cpu_we = 0; f.cpu_addr = '0; f.cpu_wdata = '0;
    f.vga_req = 0; f.vga_addr = '0; f.mem_rdata = '0; f.mem_invalid = 0;

    // Reset state
    tick(); tick();
    chk("rst_cpu_gnt",    r.cpu_gnt,    0);
    chk("rst_vga_gnt",    r.vga_gnt,    0);
    chk("rst_mem_read",   r.mem_read,   0);
    chk("rst_mem_write",  r.mem_write,  0);
    chk("rst_mem_addr",   r.mem_addr,   0);
    chk("rst_mem_wdata",  r.mem_wdata,  0);
    chk("rst_cpu_rvalid", r.cpu_rvalid, 0);
    chk("rst_cpu_rdata",  r.cpu_rdata,  0);
    chk("rst_vga_rvalid", r.vga_rvalid, 0);
    rst = 0;

    // CPU read alone
    r.cpu_req = 1; r.cpu_we = 0; r.cpu_addr = 32'h1001_0004;
    tick();
    chk("rd_gnt",      r.cpu_gnt,   1);
    chk("rd_mem_read", r.mem_read,  1);
    chk("rd_mem_wr",   r.mem_write, 0);
    chk("rd_mem_addr", r.mem_addr,  32'h1001_0004);
    r.cpu_req = 0;
    tick();
    chk("rd_wait_gnt",  r.cpu_gnt,  0);
    chk("rd_wait_strb", r.mem_read, 0);
    r.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_rvalid", r.cpu_rvalid, 1);
    chk("rd_rdata",  r.cpu_rdata,  32'hDEAD_BEEF);
    chk("rd_err",    r.cpu_err,    0);
    r.mem_rdata = '0;
    tick();
    chk("rd_rvalid_pulse", r.cpu_rvalid, 0);

    // CPU write
    r.cpu_req = 1; r.cpu_we = 1; r.cpu_addr = 32'hFFFF_0008; r.cpu_wdata = 32'h1234_5678;
    tick();
    chk("wr_gnt",       r.cpu_gnt,   1);
    chk("wr_mem_write", r.mem_write, 1);
    chk("wr_mem_read",  r.mem_read,  0);
    chk("wr_mem_addr",  r.mem_addr,  32'hFFFF_0008);
    chk("wr_mem_wdata", r.mem_wdata, 32'h1234_5678);
    r.cpu_req = 0; r.cpu_we = 0; r.mem_rdata = 32'h5555_5555;
    tick();
    chk("wr_strobe_one_cycle", r.mem_write, 0);
    tick();
    chk("wr_rvalid", r.cpu_rvalid, 1);
    chk("wr_rdata",  r.cpu_rdata,  0);
    r.mem_rdata = '0;
    tick();
    chk("wr_addr_hold",  r.mem_addr,  32'hFFFF_0008);
    chk("wr_wdata_hold", r.mem_wdata, 32'h1234_5678);

    // Round-robin tie after reset: CPU, VGA, CPU, VGA
    rst = 1; tick(); rst = 0;
    r.cpu_req = 1; r.cpu_we = 0; r.cpu_addr = 32'h1001_0000;
    r.vga_req = 1; r.vga_addr = 32'h2000_0000;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (r.cpu_gnt || r.vga_gnt) begin
        chk("rr_order", {30'd0, r.vga_gnt, r.cpu_gnt}, (n % 2 == 0) ? 32'd1 : 32'd2);
        n++;
      end
    end
    chk("rr_grant_count", n, 4);
    r.cpu_req = 0; r.vga_req = 0;
    tick(); tick(); tick();

    // Fixed priority: VGA starved while the CPU keeps requesting
    f.cpu_req = 1; f.cpu_we = 0; f.cpu_addr = 32'h1001_0000;
    f.vga_req = 1; f.vga_addr = 32'h2000_0000;
    cpu_cnt = 0; vga_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (f.cpu_gnt) cpu_cnt++;
      if (f.vga_gnt) vga_cnt++;
    end
    chk("fp_cpu_grants", cpu_cnt, 4);
    chk("fp_vga_grants", vga_cnt, 0);
    f.cpu_req = 0; f.vga_req = 0;
    tick(); tick(); tick();

    // Invalid VGA address
    r.vga_req = 1; r.vga_addr = 32'h0000_0100;
    tick();
    chk("inv_gnt",      r.vga_gnt,   1);
    chk("inv_mem_read", r.mem_read,  1);
    chk("inv_no_wr_a",  r.mem_write, 0);
    r.vga_req = 0; r.mem_invalid = 1;
    tick();
    chk("inv_no_wr_w", r.mem_write, 0);
    r.mem_invalid = 0; r.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("inv_rvalid",   r.vga_rvalid, 1);
    chk("inv_err",      r.vga_err,    1);
    chk("inv_rdata",    r.vga_rdata,  0);
    chk("inv_cpu_quiet", r.cpu_rvalid, 0);
    chk("inv_no_wr_r",  r.mem_write,  0);
    r.mem_rdata = '0;
    tick();

    // Reset during a write's ACCESS cycle
    r.cpu_req = 1; r.cpu_we = 1; r.cpu_addr = 32'hFFFF_0010; r.cpu_wdata = 32'hA5A5_A5A5;
    tick();
    chk("rma_write_on", r.mem_write, 1);
    r.cpu_req = 0; r.cpu_we = 0;
    #2 rst = 1;
    #1;
    chk("rma_write_drop", r.mem_write, 0);
    chk("rma_gnt_drop",   r.cpu_gnt,   0);
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rma_no_rvalid", r.cpu_rvalid, 0);
    end
    r.cpu_req = 1; r.cpu_addr = 32'h1001_0008;
    r.vga_req = 1; r.vga_addr = 32'h2000_0004;
    tick();
    chk("rma_tie_cpu", r.cpu_gnt, 1);
    chk("rma_tie_vga", r.vga_gnt, 0);
    r.cpu_req = 0; r.vga_req = 0;
    tick(); tick();
    chk("rma_tie_rvalid", r.cpu_rvalid, 1);
    tick();

    // VGA request raised during a CPU WAIT cycle
    r.cpu_req = 1; r.cpu_we = 0; r.cpu_addr = 32'h1001_000C;
    tick();
    chk("late_cpu_gnt", r.cpu_gnt, 1);
    r.cpu_req = 0;
    tick();
    r.vga_req = 1; r.vga_addr = 32'h2000_0008;
    chk("late_wait_no_gnt", r.vga_gnt, 0);
    tick();
    chk("late_cpu_rvalid",  r.cpu_rvalid, 1);
    chk("late_vga_not_yet", r.vga_gnt,    0);
    tick();
    chk("late_vga_gnt",  r.vga_gnt,  1);
    chk("late_vga_addr", r.mem_addr, 32'h2000_0008);
    r.vga_req = 0; r.mem_rdata = 32'h0000_0741;
    tick(); tick();
    chk("late_vga_rvalid", r.vga_rvalid, 1);
    chk("late_vga_rdata",  r.vga_rdata,  32'h0000_0741);
    chk("late_one_rvalid", r.cpu_rvalid, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter that shares the single data-memory path (address decoder plus RAM, frame-buffer and MMIO banks) between the CPU data port and the VGA text-mode refresh reader. It accepts one access at a time and drives the decoder's read/write strobes and address for exactly one cycle. It returns read data, write acknowledge and an invalid-address error to the owning requester. It sits between the CPU and VGA controller on one side and the memory decoder and bank read mux on the other.

## Interface
- RR_ENABLE, 1, 1 = round-robin between CPU and VGA; 0 = fixed priority, CPU wins
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  32  CPU virtual byte address
- cpu_wdata  in  32  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_rvalid  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  32  read data, valid with cpu_rvalid (0 for writes)
- cpu_err  out  1  invalid address, valid with cpu_rvalid
- vga_req  in  1  VGA read request, held until vga_gnt
- vga_addr  in  32  VGA virtual byte address
- vga_gnt, vga_rvalid, vga_err  out  1 each  as for the CPU
- vga_rdata  out  32  as for the CPU
- mem_read, mem_write  out  1 each  strobes to the decoder
- mem_addr  out  32  virtual address to the decoder
- mem_wdata  out  32  write data to the banks
- mem_rdata  in  32  bank-muxed read data, valid the cycle after the strobe
- mem_invalid  in  1  decoder invalidAddress, valid during the strobe cycle

## Operation
- States:
  - IDLE: sample requests.
  - ACCESS: drive strobes; cpu_gnt or vga_gnt high.
  - WAIT: memory returns data.
  - Then back to IDLE, with rvalid high in that first IDLE cycle.
- IDLE, edge with at least one request:
  - Pick an owner.
  - Latch the owner's addr, we and wdata into issue registers.
  - Go to ACCESS.
  - VGA is always a read.
- Pick rule:
  - Only one requester active: that requester wins.
  - Both active with RR_ENABLE=1: the requester that was not last_owner wins.
  - Both active with RR_ENABLE=0: CPU wins.
  - last_owner updates on each pick. Reset value is VGA, so the CPU wins the first tie.
- ACCESS:
  - mem_read = !we, mem_write = we.
  - mem_addr and mem_wdata come from the issue registers.
  - mem_invalid is registered into err at the end of the cycle.
  - Go to WAIT.
- WAIT:
  - Capture mem_rdata into the owner's rdata register; writes or err=1 load 0.
  - Go to IDLE.
  - Pulse the owner's rvalid with err in the following cycle.
- Strobes are never asserted outside ACCESS.
- mem_addr and mem_wdata hold their last latched value between accesses.
- An invalid address still runs the full ACCESS/WAIT sequence. The bank writes nothing because the decoder gives memEn=0.
- A requester may drop or change req from the cycle after gnt. Requests raised during ACCESS or WAIT wait for the next IDLE sample.
- Reset values: state=IDLE, last_owner=VGA, and every output 0 (all gnt, rvalid, rdata, err, strobes, mem_addr, mem_wdata).
- rst during ACCESS drops the strobes immediately (asynchronous). The in-flight access is abandoned and no rvalid is produced.

## Timing
- Request seen at edge E0 in IDLE:
  - gnt and strobes high during E0–E1.
  - Data returned E1–E2.
  - rvalid, rdata and err high during E2–E3.
- Earliest next sample is E3, giving throughput of one access per 3 cycles and latency of 3 cycles from sample to rvalid.
- Worst-case VGA wait with RR_ENABLE=1 and the CPU requesting back-to-back: one CPU access, i.e. 3 cycles, plus its own access.
- rvalid is a single-cycle pulse, and at most one of cpu_rvalid and vga_rvalid is high in any cycle.

## Structure
- Shared package (beside the decoder's region constants):
  - State encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2.
  - Owner encoding: OWN_CPU=1'b0, OWN_VGA=1'b1.
- Sub-module arb_pick2: combinational pick from (cpu_req, vga_req, last_owner, RR_ENABLE). It outputs a valid flag and the owner.
- Everything else stays in mem_bus_arbiter: FSM, issue registers, response registers.

## Test plan
- CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=0x10010004, mem_rdata=0xDEADBEEF in WAIT -> cpu_gnt and mem_read at cycle 1, cpu_rvalid at cycle 3 with cpu_rdata=0xDEADBEEF and cpu_err=0.
- CPU write: addr 0xFFFF0008, wdata 0x12345678 -> one-cycle mem_write with mem_addr and mem_wdata matching, then cpu_rvalid with cpu_rdata=0.
- Tie with RR_ENABLE=1, both requesting continuously -> grant order after reset is CPU, VGA, CPU, VGA; with RR_ENABLE=0 -> CPU only, VGA starved while cpu_req=1.
- Invalid address: vga_addr=0x00000100 with mem_invalid=1 -> vga_rvalid with vga_err=1 and vga_rdata=0, and no mem_write ever.
- Reset mid-ACCESS: assert rst during a CPU write's ACCESS cycle -> mem_write falls in the same cycle, no cpu_rvalid, and the next tie after release grants the CPU.
- Request timing: vga_req raised during a CPU WAIT cycle -> vga_gnt exactly one cycle after cpu_rvalid.
